cache_switch_sequencer: RTL and testbench
=========================================

CACHE_SWITCH_SEQUENCER -- requirements
Module: cache_switch_sequencer

Interface
REQ-001 Parameter LINES, default 8, lines per cache bank to scan; power of two, 2..64.
REQ-002 Parameter BANK_W, default 2, bank-select width (up to 4 banks).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 switch_req  input  1  switch-cache instruction valid in decode (switch_cache_w), level, one cycle per instruction.
REQ-006 bank_id_in  input  BANK_W  target bank, taken from the low bits of register operand data_1.
REQ-007 mem_busy  input  1  data memory has an outstanding read or write.
REQ-008 dirty_mask  input  LINES  per-line dirty bits of the active bank.
REQ-009 wb_ack  input  1  one-cycle pulse: writeback of line wb_index complete.
REQ-010 stall  output  1  freeze PC and IF/ID; hold the decode instruction.
REQ-011 wb_req  output  1  request writeback of line wb_index.
REQ-012 wb_index  output  log2(LINES)  line being scanned or written back.
REQ-013 active_bank  output  BANK_W  bank select driven to the cache.
REQ-014 switch_done  output  1  one-cycle pulse when a switch instruction retires.
REQ-015 busy  output  1  state is not IDLE.

Function
REQ-016 FSM states: IDLE, DRAIN, SCAN, WB, SWITCH; exactly one state per cycle.
REQ-017 stall = switch_req in IDLE (combinational) OR state != IDLE; it must assert in the same cycle as the request.
REQ-018 IDLE, switch_req=1, bank_id_in != active_bank: latch target <= bank_id_in, wb_index <= 0, go to DRAIN.
REQ-019 IDLE, switch_req=1, bank_id_in == active_bank: go to SWITCH; no drain and no writeback.
REQ-020 DRAIN: stay while mem_busy=1; go to SCAN in the cycle after mem_busy is seen 0.
REQ-021 SCAN, dirty_mask[wb_index]=1: go to WB.
REQ-022 SCAN, dirty_mask[wb_index]=0: if wb_index==LINES-1 go to SWITCH; else wb_index++ and stay in SCAN. Scanning costs 1 cycle per clean line.
REQ-023 WB: wb_req=1 (registered, asserted throughout WB). On wb_ack: if last line go to SWITCH, else wb_index++ and go to SCAN. wb_ack outside WB is ignored.
REQ-024 SWITCH: active_bank <= target (unchanged in the same-bank case); switch_done=1 for that cycle; go to IDLE. stall deasserts the following cycle.
REQ-025 switch_req outside IDLE is ignored (the held decode instruction re-presents it). After switch_done, switch_req is not sampled until the next IDLE cycle.
REQ-026 wb_index does not wrap: the scan ends at LINES-1; it is reset to 0 on entry to DRAIN.
REQ-027 dirty_mask is sampled live each SCAN cycle; a line dirtied after being scanned is not written back.
REQ-028 Minimum latency, different bank, all lines clean, mem_busy=0: request cycle, 1 DRAIN cycle, LINES SCAN cycles, 1 SWITCH cycle.

Reset
REQ-029 Asserted reset, any state: state=IDLE, active_bank=0, target=0, wb_index=0, wb_req=0, switch_done=0, busy=0. stall = switch_req (combinational) during reset.
REQ-030 Reset mid-WB abandons the writeback with no completion pulse. The cache must treat wb_req falling without wb_ack as a cancel.

Configuration
REQ-031 Macro CACHE_SWITCH_PERF_CNT_EN. When defined, add outputs switch_count[15:0] and wb_count[15:0].
REQ-032 switch_count increments on each switch_done pulse; wb_count increments on each accepted wb_ack. Both saturate at 16'hFFFF and reset to 0.
REQ-033 When the macro is undefined, the counter ports and logic are absent; all other behaviour is identical.

Verification
REQ-034 Reset, then switch_req=1, bank_id_in=2, dirty_mask=0, mem_busy=0: stall high 11 cycles, switch_done at cycle 10, active_bank=2.
REQ-035 active_bank=2, switch_req with bank_id_in=2: switch_done the cycle after the request, wb_req never asserts, stall high 2 cycles.
REQ-036 dirty_mask=8'b1000_0001, wb_ack 3 cycles after each wb_req: wb_req asserts for wb_index 0 then 7 only; active_bank updates after the second ack.
REQ-037 mem_busy held 5 cycles after the request: SCAN is not entered until the cycle after mem_busy falls; stall stays high throughout.
REQ-038 reset pulsed low during WB at wb_index=3: all outputs return to reset values asynchronously; a new request afterwards restarts the scan at index 0.
REQ-039 With CACHE_SWITCH_PERF_CNT_EN: 3 switches with 2 writebacks total give switch_count=3, wb_count=2; counters preset near 16'hFFFF hold at 16'hFFFF.

Source files
------------

// File: rtl/cache_switch_sequencer_if.sv
// ---------------------------------------------------------------------------
// cache_switch_sequencer_if
//
// Bundles the signals exchanged between the pipeline/cache environment and
// the cache bank-switch sequencer.
//
// Parameters
//   LINES   lines per cache bank (power of two, 2..64)
//   BANK_W  bank-select width
//
// Signals
//   switch_req   env -> seq  switch-cache instruction valid in decode
//   bank_id_in   env -> seq  requested bank (low bits of data_1)
//   mem_busy     env -> seq  data memory has an outstanding access
//   dirty_mask   env -> seq  per-line dirty bits of the active bank
//   wb_ack       env -> seq  writeback of line wb_index complete (pulse)
//   stall        seq -> env  freeze PC and IF/ID
//   wb_req       seq -> env  writeback request for line wb_index
//   wb_index     seq -> env  line being scanned / written back
//   active_bank  seq -> env  bank select driven to the cache
//   switch_done  seq -> env  switch instruction retires (pulse)
//   busy         seq -> env  sequencer is not idle
//   fsm_state    seq -> env  raw FSM state, for debug visibility
//   switch_count seq -> env  completed switches (CACHE_SWITCH_PERF_CNT_EN)
//   wb_count     seq -> env  accepted writebacks (CACHE_SWITCH_PERF_CNT_EN)
//
// Modports
//   master  the pipeline/cache environment
//   slave   the sequencer
//
// Optional feature macro: CACHE_SWITCH_PERF_CNT_EN adds the two counters.
// ---------------------------------------------------------------------------
interface cache_switch_sequencer_if #(
    parameter int LINES  = 8,
    parameter int BANK_W = 2
);
    localparam int IDX_W = $clog2(LINES);

    logic              switch_req;
    logic [BANK_W-1:0] bank_id_in;
    logic              mem_busy;
    logic [LINES-1:0]  dirty_mask;
    logic              wb_ack;
    logic              stall;
    logic              wb_req;
    logic [IDX_W-1:0]  wb_index;
    logic [BANK_W-1:0] active_bank;
    logic              switch_done;
    logic              busy;
    logic [2:0]        fsm_state;
`ifdef CACHE_SWITCH_PERF_CNT_EN
    logic [15:0]       switch_count;
    logic [15:0]       wb_count;
`endif

    modport master (
        output switch_req,
        output bank_id_in,
        output mem_busy,
        output dirty_mask,
        output wb_ack,
        input  stall,
        input  wb_req,
        input  wb_index,
        input  active_bank,
        input  switch_done,
        input  busy,
`ifdef CACHE_SWITCH_PERF_CNT_EN
        input  switch_count,
        input  wb_count,
`endif
        input  fsm_state
    );

    modport slave (
        input  switch_req,
        input  bank_id_in,
        input  mem_busy,
        input  dirty_mask,
        input  wb_ack,
        output stall,
        output wb_req,
        output wb_index,
        output active_bank,
        output switch_done,
        output busy,
`ifdef CACHE_SWITCH_PERF_CNT_EN
        output switch_count,
        output wb_count,
`endif
        output fsm_state
    );

endinterface

// File: rtl/cache_switch_sequencer.sv
// ---------------------------------------------------------------------------
// cache_switch_sequencer
//
// Sequences a switch-cache instruction: stalls the front end, waits for the
// data memory to go quiet, walks every line of the active bank writing back
// the dirty ones, then flips the bank select and retires the instruction.
// A request for the bank that is already active skips straight to the
// switch step.
//
// Ports
//   clk    single clock, all state updates on the rising edge
//   reset  asynchronous, active-low reset
//   bus    cache_switch_sequencer_if.slave (see the interface header)
//
// Parameters
//   LINES   lines per bank to scan (power of two, 2..64)
//   BANK_W  bank-select width
//
// Optional feature macro: CACHE_SWITCH_PERF_CNT_EN adds saturating 16-bit
// switch_count / wb_count outputs on the interface.
//
// Writeback handshake: wb_req acts as valid and wb_ack as a one-cycle ready.
// wb_req rises with wb_index stable and stays high until the cycle wb_ack is
// seen; the line is complete on the rising edge where wb_req and wb_ack are
// both high. wb_ack with wb_req low is ignored. wb_req falling without an
// accompanying wb_ack (only possible through reset) means the writeback was
// cancelled.
// ---------------------------------------------------------------------------
module cache_switch_sequencer #(
    parameter int LINES  = 8,
    parameter int BANK_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    cache_switch_sequencer_if.slave bus
);

    localparam int IDX_W = $clog2(LINES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRAIN  = 3'd1;
    localparam logic [2:0] S_SCAN   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_SWITCH = 3'd4;

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [BANK_W-1:0] target_q;
    logic [BANK_W-1:0] target_d;
    logic [BANK_W-1:0] bank_q;
    logic [BANK_W-1:0] bank_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic              wb_req_q;
    logic              last_line;
    logic              line_dirty;

    assign last_line  = (idx_q == LAST_IDX);
    // Sampled live: a line dirtied after its scan cycle is left alone.
    assign line_dirty = bus.dirty_mask[idx_q];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        bank_d   = bank_q;
        idx_d    = idx_q;

        case (state_q)
            S_IDLE: begin
                if (bus.switch_req) begin
                    // Target always equals the active bank in the same-bank
                    // case, so latching it unconditionally is harmless.
                    target_d = bus.bank_id_in;
                    if (bus.bank_id_in != bank_q) begin
                        idx_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_SWITCH;
                    end
                end
            end

            S_DRAIN: begin
                if (!bus.mem_busy) begin
                    state_d = S_SCAN;
                end
            end

            S_SCAN: begin
                if (line_dirty) begin
                    state_d = S_WB;
                end else if (last_line) begin
                    state_d = S_SWITCH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            S_WB: begin
                if (bus.wb_ack) begin
                    if (last_line) begin
                        state_d = S_SWITCH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_SCAN;
                    end
                end
            end

            S_SWITCH: begin
                bank_d  = target_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            bank_q   <= '0;
            idx_q    <= '0;
            wb_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            bank_q   <= bank_d;
            idx_q    <= idx_d;
            // Registered so wb_req is high for exactly the cycles spent in WB.
            wb_req_q <= (state_d == S_WB);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The request must stall in its own cycle, before the FSM has moved.
    assign bus.stall       = (state_q != S_IDLE) || bus.switch_req;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.switch_done = (state_q == S_SWITCH);
    assign bus.wb_req      = wb_req_q;
    assign bus.wb_index    = idx_q;
    assign bus.active_bank = bank_q;
    assign bus.fsm_state   = state_q;

`ifdef CACHE_SWITCH_PERF_CNT_EN
    // -----------------------------------------------------------------------
    // Saturating performance counters
    // -----------------------------------------------------------------------
    logic [15:0] switch_cnt_q;
    logic [15:0] wb_cnt_q;
    logic        wb_accept;

    assign wb_accept = (state_q == S_WB) && bus.wb_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            switch_cnt_q <= '0;
            wb_cnt_q     <= '0;
        end else begin
            if ((state_q == S_SWITCH) && (switch_cnt_q != 16'hFFFF)) begin
                switch_cnt_q <= switch_cnt_q + 16'd1;
            end
            if (wb_accept && (wb_cnt_q != 16'hFFFF)) begin
                wb_cnt_q <= wb_cnt_q + 16'd1;
            end
        end
    end

    assign bus.switch_count = switch_cnt_q;
    assign bus.wb_count     = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_switch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cache_switch_sequencer
//
// Self-checking bench for cache_switch_sequencer (LINES=8, BANK_W=2).
// A transaction-level model predicts, cycle by cycle, the observable outputs
// {stall, busy, wb_req, switch_done, wb_index, active_bank} of each switch
// from the bank requested, the mem_busy duration, the dirty mask seen on
// each cycle and the writeback acknowledge latency. Directed scenarios cover
// the minimum-latency switch, the same-bank switch, sparse writebacks,
// memory drain, reset in the middle of a writeback and (with
// CACHE_SWITCH_PERF_CNT_EN) the counters; randomized switches follow.
// ---------------------------------------------------------------------------
module tb_cache_switch_sequencer;

    localparam int LINES  = 8;
    localparam int BANK_W = 2;
    localparam int IDX_W  = 3;
    localparam int W      = 4 + IDX_W + BANK_W;
    localparam int MAXC   = 64;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cache_switch_sequencer_if #(.LINES(LINES), .BANK_W(BANK_W)) bus ();

    cache_switch_sequencer #(
        .LINES  (LINES),
        .BANK_W (BANK_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;

    logic [W-1:0]     exp_q[$];
    int               obs_wb_q[$];
    logic [LINES-1:0] mask_seq[MAXC];
    int               lat_arr[LINES];

    // Model of architectural state carried between transactions.
    int model_bank = 0;
    int model_idx  = 0;
    int exp_sw     = 0;
    int exp_wb     = 0;

    // Observations from the last transaction.
    int obs_done_cyc;
    int obs_stall_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit st, input bit bz, input bit wr, input bit dn, input int idx);
        exp_q.push_back({st, bz, wr, dn, IDX_W'(idx), BANK_W'(model_bank)});
    endtask

    // Reference model: builds the expected per-cycle output sequence of one
    // switch instruction, cycle 0 being the request cycle.
    task automatic model_txn(input int b, input int d);
        int c;
        int k;
        bit dirty;
        exp_q.delete();
        if (b == model_bank) begin
            push_exp(1, 0, 0, 0, model_idx);
            push_exp(1, 1, 0, 1, model_idx);
        end else begin
            push_exp(1, 0, 0, 0, model_idx);
            c = 1;
            // Drain: memory is busy for cycles 0..d-1; leave once idle seen.
            while (1) begin
                push_exp(1, 1, 0, 0, 0);
                c++;
                if (c - 1 >= d) break;
            end
            k = 0;
            for (int i = 0; i < LINES; i++) begin
                dirty = mask_seq[c][i];
                push_exp(1, 1, 0, 0, i);
                c++;
                if (dirty) begin
                    for (int j = 0; j < lat_arr[k]; j++) begin
                        push_exp(1, 1, 1, 0, i);
                        c++;
                    end
                    k++;
                    exp_wb++;
                end
            end
            push_exp(1, 1, 0, 1, LINES - 1);
            model_idx = LINES - 1;
        end
        model_bank = b;
        exp_sw++;
    endtask

    // ---------------- driver + monitor ----------------
    // lat=0 picks a random acknowledge latency (1..4 cycles of wb_req) per
    // writeback; churn re-randomizes dirty bits every cycle.
    task automatic run_txn(input int b, input int d, input logic [LINES-1:0] base,
                           input bit churn, input int lat);
        int n;
        int run;
        int k;
        bit prev_wr;
        logic [W-1:0] e;
        logic [W-1:0] o;
        for (int c = 0; c < MAXC; c++) begin
            mask_seq[c] = churn ? (base ^ LINES'($urandom & $urandom)) : base;
        end
        for (int i = 0; i < LINES; i++) begin
            lat_arr[i] = (lat > 0) ? lat : $urandom_range(1, 4);
        end
        model_txn(b, d);
        n = exp_q.size();
        run = 0;
        k = 0;
        prev_wr = 1'b0;
        obs_done_cyc = -1;
        obs_stall_cnt = 0;
        obs_wb_q.delete();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            bus.switch_req = 1'b1;
            bus.bank_id_in = BANK_W'(b);
            bus.mem_busy   = (c < d);
            bus.dirty_mask = mask_seq[c];
            if (bus.wb_req) begin
                run++;
                if (run >= ((k < LINES) ? lat_arr[k] : 1)) begin
                    bus.wb_ack = 1'b1;
                    run = 0;
                    k++;
                end else begin
                    bus.wb_ack = 1'b0;
                end
            end else begin
                run = 0;
                // Stray acknowledges outside a writeback must be ignored.
                bus.wb_ack = ($urandom_range(0, 3) == 0);
            end
            #1;
            if (bus.stall) obs_stall_cnt++;
            if (bus.switch_done && obs_done_cyc < 0) obs_done_cyc = c;
            if (bus.wb_req && !prev_wr) obs_wb_q.push_back(int'(bus.wb_index));
            prev_wr = bus.wb_req;
            e = exp_q.pop_front();
            o = {bus.stall, bus.busy, bus.wb_req, bus.switch_done, bus.wb_index, bus.active_bank};
            check($sformatf("cyc%0d_b%0d", c, b), o, e);
        end
        @(negedge clk);
        bus.switch_req = 1'b0;
        bus.mem_busy   = 1'b0;
        bus.wb_ack     = 1'b0;
        bus.dirty_mask = LINES'($urandom);
        #1;
        check("post_stall", bus.stall, 0);
        check("post_busy", bus.busy, 0);
        check("post_bank", bus.active_bank, model_bank);
    endtask

    task automatic reset_mid_wb();
        int seen;
        logic [BANK_W-1:0] tgt;
        tgt = BANK_W'(model_bank + 1);
        seen = 0;
        @(negedge clk);
        bus.switch_req = 1'b1;
        bus.bank_id_in = tgt;
        bus.mem_busy   = 1'b0;
        bus.dirty_mask = 8'b0000_1000;
        bus.wb_ack     = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.wb_req) begin
                seen = 1;
                break;
            end
        end
        check("rst_wb_seen", seen, 1);
        check("rst_wb_idx", bus.wb_index, 3);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_wbreq", bus.wb_req, 0);
        check("rst_async_busy", bus.busy, 0);
        check("rst_async_done", bus.switch_done, 0);
        check("rst_async_idx", bus.wb_index, 0);
        check("rst_async_bank", bus.active_bank, 0);
        check("rst_async_stall_req", bus.stall, 1);
        bus.switch_req = 1'b0;
        #1;
        check("rst_async_stall_noreq", bus.stall, 0);
        @(negedge clk);
        #1;
        check("rst_hold_busy", bus.busy, 0);
        check("rst_hold_wbreq", bus.wb_req, 0);
        reset = 1'b1;
        model_bank = 0;
        model_idx  = 0;
        exp_sw     = 0;
        exp_wb     = 0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.switch_req = 1'b0;
        bus.bank_id_in = '0;
        bus.mem_busy   = 1'b0;
        bus.dirty_mask = '0;
        bus.wb_ack     = 1'b0;

        // Reset values, including the combinational stall path.
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_wbreq", bus.wb_req, 0);
        check("rst_done", bus.switch_done, 0);
        check("rst_idx", bus.wb_index, 0);
        check("rst_bank", bus.active_bank, 0);
        check("rst_stall_lo", bus.stall, 0);
        bus.switch_req = 1'b1;
        #1;
        check("rst_stall_hi", bus.stall, 1);
        @(negedge clk);
        bus.switch_req = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Minimum-latency switch to bank 2, all lines clean.
        run_txn(2, 0, 8'h00, 1'b0, 1);
        check("min_done_cyc", obs_done_cyc, 10);
        check("min_stall_cnt", obs_stall_cnt, 11);
        check("min_wb_none", obs_wb_q.size(), 0);

        // Same-bank request: immediate retire.
        run_txn(2, 0, 8'hFF, 1'b0, 1);
        check("same_done_cyc", obs_done_cyc, 1);
        check("same_stall_cnt", obs_stall_cnt, 2);
        check("same_wb_none", obs_wb_q.size(), 0);

        // Lines 0 and 7 dirty, ack 3 cycles after each request.
        run_txn(1, 0, 8'b1000_0001, 1'b0, 4);
        check("sparse_wb_cnt", obs_wb_q.size(), 2);
        if (obs_wb_q.size() == 2) begin
            check("sparse_wb_first", obs_wb_q[0], 0);
            check("sparse_wb_second", obs_wb_q[1], 7);
        end

        // Memory busy for 5 cycles from the request.
        run_txn(3, 5, LINES'($urandom), 1'b0, 0);
        check("drain_stall_cnt", obs_stall_cnt, obs_done_cyc + 1);

        // Reset in the middle of the writeback of line 3.
        reset_mid_wb();
        repeat (2) @(negedge clk);

        // Three switches, two writebacks, restarting from index 0.
        run_txn(1, 0, 8'b0000_0001, 1'b0, 2);
        if (obs_wb_q.size() > 0) check("restart_first_idx", obs_wb_q[0], 0);
        else check("restart_wb_cnt", obs_wb_q.size(), 1);
        run_txn(1, 0, 8'h00, 1'b0, 1);
        run_txn(2, 1, 8'b1000_0000, 1'b0, 3);
`ifdef CACHE_SWITCH_PERF_CNT_EN
        check("perf_switch_count", bus.switch_count, 3);
        check("perf_wb_count", bus.wb_count, 2);
`endif

        // Randomized switches.
        for (int t = 0; t < 25; t++) begin
            run_txn($urandom_range(0, 3), $urandom_range(0, 5), LINES'($urandom),
                    bit'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

`ifdef CACHE_SWITCH_PERF_CNT_EN
        check("perf_switch_total", bus.switch_count, exp_sw);
        check("perf_wb_total", bus.wb_count, exp_wb);
        @(negedge clk);
        dut.switch_cnt_q = 16'hFFFE;
        dut.wb_cnt_q     = 16'hFFFE;
        run_txn((model_bank + 1) % 4, 0, 8'b0101_0101, 1'b0, 1);
        run_txn(model_bank, 0, 8'h00, 1'b0, 1);
        check("perf_switch_sat", bus.switch_count, 16'hFFFF);
        check("perf_wb_sat", bus.wb_count, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
